// File: rtl/mem_arb2.sv
// Two-master (instruction/data) to one-target SRAM arbiter with an in-order tag FIFO
// steering responses. Define MEM_ARB2_ROUND_ROBIN_EN for alternating grant on contention.
module mem_arb2 #(
    parameter int C_OUTSTANDING = 2,
    parameter int C_ADDR_SZ     = 32
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    input  logic                 clk_en_i,
    output logic                 ireqready_o,
    input  logic                 ireqvalid_i,
    input  logic [C_ADDR_SZ-1:0] ireqaddr_i,
    input  logic                 irspready_i,
    output logic                 irspvalid_o,
    output logic                 irsprerr_o,
    output logic [31:0]          irspdata_o,
    output logic                 dreqready_o,
    input  logic                 dreqvalid_i,
    input  logic                 dreqdvalid_i,
    input  logic [1:0]           dreqsize_i,
    input  logic [C_ADDR_SZ-1:0] dreqaddr_i,
    input  logic [31:0]          dreqdata_i,
    input  logic                 drspready_i,
    output logic                 drspvalid_o,
    output logic                 drsprerr_o,
    output logic [31:0]          drspdata_o,
    input  logic                 treqready_i,
    output logic                 treqvalid_o,
    output logic                 treqdvalid_o,
    output logic [1:0]           treqsize_o,
    output logic [C_ADDR_SZ-1:0] treqaddr_o,
    output logic [31:0]          treqdata_o,
    output logic                 trspready_o,
    input  logic                 trspvalid_i,
    input  logic                 trsprerr_i,
    input  logic [31:0]          trspdata_i
);

    localparam int PW = (C_OUTSTANDING > 1) ? $clog2(C_OUTSTANDING) : 1;
    localparam int CW = $clog2(C_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(C_OUTSTANDING);

    logic [C_OUTSTANDING-1:0] tag_q;   // 0 = instruction, 1 = data
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [CW-1:0]            count_q;
    logic                     last_gnt_q;

    logic full;
    logic empty;
    logic prio_d;
    logic gnt_d;
    logic push;
    logic pop;
    logic head_d;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

`ifdef MEM_ARB2_ROUND_ROBIN_EN
    assign prio_d = ~last_gnt_q;
`else
    // last-grant is tracked but never steers the fixed-priority choice
    assign prio_d = last_gnt_q | 1'b1;
`endif

    // Idle defaults to the data mux so all forwarded fields read 0 with quiet inputs.
    assign gnt_d = ~ireqvalid_i | (dreqvalid_i & prio_d);

    assign treqvalid_o = (ireqvalid_i | dreqvalid_i) & ~full;
    assign ireqready_o = ~gnt_d & ireqvalid_i & treqready_i & ~full;
    assign dreqready_o =  gnt_d & dreqvalid_i & treqready_i & ~full;

    assign treqdvalid_o = gnt_d ? dreqdvalid_i : 1'b0;
    assign treqsize_o   = gnt_d ? dreqsize_i   : 2'b10;
    assign treqaddr_o   = gnt_d ? dreqaddr_i   : ireqaddr_i;
    assign treqdata_o   = gnt_d ? dreqdata_i   : 32'h0;

    assign head_d      = tag_q[rd_ptr_q];
    assign irspvalid_o = ~empty & ~head_d & trspvalid_i;
    assign drspvalid_o = ~empty &  head_d & trspvalid_i;
    assign trspready_o = ~empty & (head_d ? drspready_i : irspready_i);
    assign irsprerr_o  = trsprerr_i;
    assign drsprerr_o  = trsprerr_i;
    assign irspdata_o  = trspdata_i;
    assign drspdata_o  = trspdata_i;

    assign push = treqvalid_o & treqready_i;
    assign pop  = trspvalid_i & trspready_o;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_gnt_q <= 1'b0;
        end else if (clk_en_i) begin
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_d;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                last_gnt_q      <= gnt_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-master to one-target memory arbiter that lets the merlin32i instruction port and data port share a single synchronous SRAM target (ssram-style treq/trsp interface). It selects one request per cycle, forwards it downstream, and records the winning master in an in-order tag FIFO. Returning responses are steered back to the correct master from that FIFO. It sits between the core and the memory wherever a unified instruction/data memory replaces the separate boot ROM plus data SRAM.

## Interface
Parameters:
- C_OUTSTANDING, 2, maximum accepted-but-unanswered requests (tag FIFO depth); power of two, ≥2
- C_ADDR_SZ, 32, address width

Ports (clock, reset first; clock is `clk_i`, reset is `resetb_i`, one clock, reset asynchronous active-low):
- clk_i  in  1  clock
- resetb_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  clock enable; when 0 all state holds
- ireqready_o  out  1  instruction request accepted
- ireqvalid_i  in  1  instruction read request valid
- ireqaddr_i  in  C_ADDR_SZ  instruction address
- irspready_i  in  1  instruction master can take response
- irspvalid_o  out  1  instruction response valid
- irsprerr_o  out  1  instruction read error
- irspdata_o  out  32  instruction response data
- dreqready_o  out  1  data request accepted
- dreqvalid_i  in  1  data request valid
- dreqdvalid_i  in  1  1 = write, 0 = read
- dreqsize_i  in  2  access size (byte/half/word)
- dreqaddr_i  in  C_ADDR_SZ  data address
- dreqdata_i  in  32  write data
- drspready_i  in  1  data master can take response
- drspvalid_o  out  1  data response valid
- drsprerr_o  out  1  data read error
- drspdata_o  out  32  data response data
- treqready_i  in  1  target accepts request
- treqvalid_o  out  1  target request valid
- treqdvalid_o, treqsize_o, treqaddr_o, treqdata_o  out  1/2/C_ADDR_SZ/32  forwarded request fields
- trspready_o  out  1  arbiter takes target response
- trspvalid_i  in  1  target response valid
- trsprerr_i  in  1  target read error
- trspdata_i  in  32  target response data

## Operation
- State: tag FIFO (1-bit master tag per entry, 0=I, 1=D), read/write pointers, occupancy count (0..C_OUTSTANDING), last-grant bit.
- Request path combinational from registered state: full = (count == C_OUTSTANDING). If full, treqvalid_o=0 and both upstream readies 0.
- Grant: only one valid → that master. Both valid → priority policy (see Configuration).
- treqvalid_o = granted valid & !full; request fields mux from granted master; instruction requests drive treqdvalid_o=0, treqsize_o=2'b10, treqdata_o=0.
- Granted master's ready = treqready_i & !full; loser's ready = 0.
- Accept (treqvalid_o & treqready_i): push granted tag; update last-grant.
- Every request (read or write) produces exactly one in-order response from the target.
- Response path: empty → trspready_o=0, both rspvalid 0. Non-empty → head tag selects: irspvalid_o/drspvalid_o = trspvalid_i for the selected master only; trspready_o = selected master's rspready; data/rerr broadcast to both, qualified by valid.
- Response transfer (trspvalid_i & trspready_o): pop.
- Simultaneous push and pop: count unchanged, both pointers advance. Full blocks acceptance even if a pop occurs that cycle (no response→request combinational path).
- trspvalid_i while empty: ignored (protocol violation, not absorbed).

## Timing
- Zero added request latency (combinational pass-through); zero added response latency.
- Reset values: count=0, pointers=0, last-grant=I; thus all *valid_o/*ready_o = 0 except none asserted until inputs arrive; all data outputs follow muxes (0 with zero inputs).
- Reset mid-operation: outstanding tags discarded; responses arriving after reset are ignored until new requests accepted.
- Upstream masters must hold valid/fields stable until ready; arbiter may switch grant only between accepts (grant re-evaluated each cycle but last-grant changes only on accept).

## Configuration
- MEM_ARB2_ROUND_ROBIN_EN defined: on contention grant the master not equal to last-grant (alternate); after reset data wins first contention.
- Not defined: fixed priority, data port always wins contention; last-grant register still present but unused for selection.

## Test plan
- Single I read addr 0x100, target returns 0xDEADBEEF after 1 cycle → irspvalid_o with 0xDEADBEEF, drspvalid_o stays 0.
- I and D both valid for 4 accepts, target always ready → RR: D,I,D,I; fixed: D,D,D,D with ireqready_o held 0.
- Target stalls responses, C_OUTSTANDING=2: two accepts, then third request sees treqvalid_o=0 until first response pops; accept resumes next cycle.
- Interleaved D write 0x200←0x12345678 then I read: responses routed D then I in order; drspready_i=0 backpressures trspready_o=0 while head is D.
- Assert resetb_i=0 with 2 outstanding → count 0, all valids 0 asynchronously; stray trspvalid_i afterward produces no rspvalid.
- clk_en_i=0 during contention → no pointer/count/last-grant change.
